// File: rtl/sha1_digest_stream.sv
// sha1_digest_stream: captures the SHA-1 digest on the rising edge of sha_done
// and replays it as a DATA_W valid/ready stream, most-significant word first.
// A digest arriving mid-stream is dropped and flagged in a sticky overflow bit,
// except on the last-word handshake, where it is chained back-to-back.
// Optional build macro: DIGEST_BYTE_SWAP_EN byte-reverses every output word.
module sha1_digest_stream #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIGEST_W = 160
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sha_done,
  input  logic [DIGEST_W-1:0] hash_out,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int unsigned NWORDS = DIGEST_W / DATA_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                done_q;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    idx_inc;
  logic                last_q, last_d;
  logic                ovf_q, ovf_d;
  logic                capture;
  logic                handshake;
  logic                last_hs;
  logic                load;
  logic [DATA_W-1:0]   word;

  // Event decode: rising edge of sha_done and stream handshakes
  assign capture   = sha_done & ~done_q;
  assign handshake = (state_q == SEND) & m_ready;
  assign last_hs   = handshake & (idx_q == LAST_IDX);
  assign load      = capture & ((state_q == IDLE) | last_hs);
  assign idx_inc   = idx_q + IDX_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a capture on the last handshake keeps us in SEND
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = SEND;
      SEND: if (last_hs && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state register
  always_comb begin
    m_valid  = 1'b0;
    busy     = 1'b0;
    m_last   = last_q;
    overflow = ovf_q;
    if (state_q == SEND) begin
      m_valid = 1'b1;
      busy    = 1'b1;
    end
  end

  // Datapath next values: the digest is a shift register so the head word
  // is always the word being offered
  always_comb begin
    digest_d = digest_q;
    idx_d    = idx_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    if (load) begin
      digest_d = hash_out;
      idx_d    = '0;
      last_d   = (LAST_IDX == '0);
    end else if (handshake) begin
      if (last_hs) begin
        last_d = 1'b0;
      end else begin
        digest_d = digest_q << DATA_W;
        idx_d    = idx_inc;
        last_d   = (idx_inc == LAST_IDX);
      end
    end
    if (clr_overflow) ovf_d = 1'b0;
    if (capture && (state_q == SEND) && !last_hs) ovf_d = 1'b1;
  end

  // Datapath registers; the edge detector resets high so a level already
  // present at reset release is not mistaken for a new digest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b1;
      digest_q <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q   <= sha_done;
      digest_q <= digest_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  assign word = digest_q[DIGEST_W-1 -: DATA_W];

`ifdef DIGEST_BYTE_SWAP_EN
  // Byte-reverse the head word for little-endian consumers
  always_comb begin
    m_data = '0;
    for (int b = 0; b < int'(DATA_W / 8); b++) begin
      m_data[8*b +: 8] = word[DATA_W-8-8*b +: 8];
    end
  end
`else
  assign m_data = word;
`endif

endmodule

// File: tb/tb_sha1_digest_stream.sv
// Directed bench for sha1_digest_stream: basic stream, backpressure,
// back-to-back digests, overflow drop/clear and mid-stream reset.
module tb_sha1_digest_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sha_done;
  logic [159:0] hash_out;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         busy;
  logic         overflow;
  logic         clr_overflow;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];

  localparam logic [159:0] DIG_A = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_B = 160'h00000001_00000002_00000003_00000004_00000005;

  sha1_digest_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sha_done     (sha_done),
    .hash_out     (hash_out),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [159:0] d, input int i);
    logic [31:0] w;
    w = d[159-32*i -: 32];
`ifdef DIGEST_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  // Stream monitor: records handshakes and checks stall stability
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        got_cyc.push_back(cyc_cnt);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (got_data.size() < n && k < 200) begin
      cyc();
      k++;
    end
    chk("word_count", 32'(got_data.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag, input logic [159:0] d, input int base);
    for (int i = 0; i < 5; i++) begin
      if (base + i < got_data.size()) begin
        chk({tag, "_data"}, got_data[base+i], exp_word(d, i));
        chk({tag, "_last"}, 32'(got_last[base+i]), 32'(i == 4));
      end else begin
        chk({tag, "_missing"}, 32'(got_data.size()), 32'(base + i + 1));
      end
    end
  endtask

  int pat[6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    rst_n        = 1'b0;
    sha_done     = 1'b0;
    hash_out     = '0;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // Test 1: basic stream, sha_done held for 3 cycles
    clear_q();
    m_ready  = 1'b1;
    hash_out = DIG_A;
    sha_done = 1'b1;
    chk("t1_valid_pre", 32'(m_valid), 32'd0);
    cyc();
    chk("t1_valid_lat", 32'(m_valid), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_word0", m_data, exp_word(DIG_A, 0));
    cyc();
    cyc();
    sha_done = 1'b0;
    wait_words(5);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(m_valid), 32'd0);
    check_stream("t1", DIG_A, 0);
    repeat (10) cyc();
    chk("t1_once", 32'(got_data.size()), 32'd5);

    // Test 2: backpressure with a 1,0,0,1,0,1 ready pattern
    clear_q();
    m_ready  = 1'b0;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    for (int i = 0; i < 60 && got_data.size() < 5; i++) begin
      m_ready = pat[i%6][0];
      cyc();
    end
    m_ready = 1'b1;
    wait_words(5);
    check_stream("t2", DIG_A, 0);
    chk("t2_ovf", 32'(overflow), 32'd0);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Test 3: back-to-back digest on the last-word handshake
    clear_q();
    repeat (2) cyc();
    hash_out = DIG_A;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    repeat (4) cyc();
    hash_out = DIG_B;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    wait_words(10);
    check_stream("t3a", DIG_A, 0);
    check_stream("t3b", DIG_B, 5);
    if (got_cyc.size() >= 10) chk("t3_no_bubble", 32'(got_cyc[9] - got_cyc[0]), 32'd9);
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Test 4: drop while index = 2, then clear
    clear_q();
    repeat (2) cyc();
    hash_out = DIG_A;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    cyc();
    cyc();
    hash_out = DIG_B;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    wait_words(5);
    check_stream("t4", DIG_A, 0);
    repeat (10) cyc();
    chk("t4_dropped", 32'(got_data.size()), 32'd5);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Test 5: reset after two handshakes, sha_done high across release
    clear_q();
    repeat (2) cyc();
    hash_out = DIG_A;
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    cyc();
    cyc();
    chk("t5_pre_rst_cnt", 32'(got_data.size()), 32'd2);
    #2;
    rst_n    = 1'b0;
    sha_done = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_data", m_data, 32'd0);
    chk("t5_rst_last", 32'(m_last), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    cyc();
    rst_n = 1'b1;
    clear_q();
    repeat (3) cyc();
    chk("t5_no_cap_valid", 32'(m_valid), 32'd0);
    chk("t5_no_cap_busy", 32'(busy), 32'd0);
    sha_done = 1'b0;
    cyc();
    sha_done = 1'b1;
    cyc();
    sha_done = 1'b0;
    chk("t5_recap_valid", 32'(m_valid), 32'd1);
    wait_words(5);
    check_stream("t5", DIG_A, 0);

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
